// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter.
// Define PS2_TX_ACK_CHECK_EN to report a device NACK on txError.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetLow,
  input  logic [7:0] cmdData,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       ps2ClkIn,
  input  logic       ps2DatIn,
  output logic       ps2ClkDriveLow,
  output logic       ps2DatDriveLow,
  output logic       busy,
  output logic       txDone,
  output logic       txError
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES)
                         ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_drv_q, clk_drv_d;
  logic          dat_drv_q, dat_drv_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          nack_q, nack_d;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;
  logic          timeout;
  logic          abort;

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign timeout = (cnt_q == TO_LAST) & ~fall;

  assign cmdReady       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign ps2ClkDriveLow = clk_drv_q;
  assign ps2DatDriveLow = dat_drv_q;
  assign txDone         = done_q;
  assign txError        = err_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmdValid) begin
          state_d   = S_INHIBIT;
          shift_d   = {1'b1, ~^cmdData, cmdData};
          bit_d     = 4'd0;
          cnt_d     = '0;
          nack_d    = 1'b0;
          clk_drv_d = 1'b1;
          dat_drv_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = S_START;
          dat_drv_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: begin
        state_d   = S_SEND;
        clk_drv_d = 1'b0;
      end
      S_SEND: begin
        if (fall) begin
          dat_drv_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_d     = bit_q + 4'd1;
          cnt_d     = '0;
          if (bit_q == 4'd9) state_d = S_ACK;
        end else if (timeout) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACK: begin
        if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          nack_d = dat_s2_q;
`else
          nack_d = 1'b0;
`endif
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (timeout) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        // done_q marks the final RELEASE cycle; IDLE follows it
        if (done_q) begin
          state_d = S_IDLE;
        end else if (clk_s2_q & dat_s2_q) begin
          done_d = 1'b1;
          err_d  = nack_q;
        end else if (timeout) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_RELEASE;
      clk_drv_d = 1'b0;
      dat_drv_d = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      clk_drv_q  <= 1'b0;
      dat_drv_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      nack_q     <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      clk_drv_q  <= clk_drv_d;
      dat_drv_q  <= dat_drv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      nack_q     <= nack_d;
      clk_s1_q   <= ps2ClkIn;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2DatIn;
      dat_s2_q   <= dat_s1_q;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a clocking PS/2 device model.
// Drives at negedge, samples at negedge; expected bits come from the byte.
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TMO = 200;

`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit NACK_FLAGGED = 1'b1;
`else
  localparam bit NACK_FLAGGED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetLow = 1'b0;
  logic [7:0] cmdData = 8'h00;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic       ps2ClkIn;
  logic       ps2DatIn;
  logic       ps2ClkDriveLow;
  logic       ps2DatDriveLow;
  logic       busy;
  logic       txDone;
  logic       txError;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int last_fall = 0;
  int done_cyc  = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .resetLow      (resetLow),
    .cmdData       (cmdData),
    .cmdValid      (cmdValid),
    .cmdReady      (cmdReady),
    .ps2ClkIn      (ps2ClkIn),
    .ps2DatIn      (ps2DatIn),
    .ps2ClkDriveLow(ps2ClkDriveLow),
    .ps2DatDriveLow(ps2DatDriveLow),
    .busy          (busy),
    .txDone        (txDone),
    .txError       (txError)
  );

  // open-drain wired-AND of host and device
  assign ps2ClkIn = ~(ps2ClkDriveLow | dev_clk_low);
  assign ps2DatIn = ~(ps2DatDriveLow | dev_dat_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // drive level after each of falling edges 1..10: data LSB first,
  // odd parity, stop; a 1 bit is released, a 0 bit is pulled low
  function automatic logic [9:0] expected_drive(input logic [7:0] b);
    logic [9:0] e;
    logic       par;
    par = (($countones(b) % 2) == 0);
    for (int i = 0; i < 8; i++) e[i] = ~b[i];
    e[8] = ~par;
    e[9] = 1'b0;
    return e;
  endfunction

  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    cmdData  = b;
    cmdValid = 1'b1;
    total_cnt++;
    if (cmdReady !== 1'b1)
      $display("FAIL accept_ready: got %b want 1", cmdReady);
    else pass_cnt++;
    @(negedge clk);
    cmdValid = 1'b0;
    cmdData  = 8'($urandom);
    total_cnt++;
    if (busy !== 1'b1 || ps2ClkDriveLow !== 1'b1)
      $display("FAIL accept_inhibit: busy=%b clkdrv=%b want 1 1",
               busy, ps2ClkDriveLow);
    else pass_cnt++;
  endtask

  task automatic run_inhibit();
    int n = 0;
    while (ps2ClkDriveLow === 1'b1 && ps2DatDriveLow === 1'b0
           && n < 4 * INH) begin
      n++;
      @(negedge clk);
    end
    total_cnt++;
    if (n != INH)
      $display("FAIL inhibit_len: got %0d want %0d", n, INH);
    else pass_cnt++;
    total_cnt++;
    if (ps2ClkDriveLow !== 1'b1 || ps2DatDriveLow !== 1'b1)
      $display("FAIL start_drive: clk=%b dat=%b want 1 1",
               ps2ClkDriveLow, ps2DatDriveLow);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ps2ClkDriveLow !== 1'b0 || ps2DatDriveLow !== 1'b1)
      $display("FAIL send_start: clk=%b dat=%b want 0 1",
               ps2ClkDriveLow, ps2DatDriveLow);
    else pass_cnt++;
  endtask

  task automatic run_frame(input logic [7:0] b, input int nfalls,
                           input bit ack);
    logic [9:0] exp_bits;
    exp_bits = expected_drive(b);
    repeat (5) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      if (i == 10) dev_dat_low = ack;
      repeat (10) @(negedge clk);
      if (i < 10) begin
        total_cnt++;
        if (ps2DatDriveLow !== exp_bits[i] || ps2ClkDriveLow !== 1'b0)
          $display("FAIL bit%0d byte %h: dat=%b clk=%b want %b 0",
                   i, b, ps2DatDriveLow, ps2ClkDriveLow, exp_bits[i]);
        else pass_cnt++;
      end
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      if (i < 10) repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_done(input bit exp_err, input int budget);
    int n = 0;
    while (txDone !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    total_cnt++;
    if (txDone !== 1'b1)
      $display("FAIL done_wait: txDone=%b after %0d cycles want 1",
               txDone, n);
    else pass_cnt++;
    total_cnt++;
    if (txError !== exp_err)
      $display("FAIL done_error: got %b want %b", txError, exp_err);
    else pass_cnt++;
    total_cnt++;
    if (ps2ClkDriveLow !== 1'b0 || ps2DatDriveLow !== 1'b0
        || busy !== 1'b1)
      $display("FAIL done_bus: clk=%b dat=%b busy=%b want 0 0 1",
               ps2ClkDriveLow, ps2DatDriveLow, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (cmdReady !== 1'b1 || txDone !== 1'b0 || busy !== 1'b0)
      $display("FAIL after_done: ready=%b done=%b busy=%b want 1 0 0",
               cmdReady, txDone, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    resetLow = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (cmdReady !== 1'b1 || busy !== 1'b0 || ps2ClkDriveLow !== 1'b0
        || ps2DatDriveLow !== 1'b0 || txDone !== 1'b0 || txError !== 1'b0)
      $display("FAIL reset_state: rdy=%b busy=%b c=%b d=%b dn=%b er=%b want 1 0 0 0 0 0",
               cmdReady, busy, ps2ClkDriveLow, ps2DatDriveLow, txDone,
               txError);
    else pass_cnt++;
    resetLow = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (cmdReady !== 1'b1 || busy !== 1'b0 || ps2ClkDriveLow !== 1'b0)
      $display("FAIL reset_idle: rdy=%b busy=%b clk=%b want 1 0 0",
               cmdReady, busy, ps2ClkDriveLow);
    else pass_cnt++;
  endtask

  task automatic test_send(input logic [7:0] b, input bit ack);
    accept(b);
    run_inhibit();
    run_frame(b, 11, ack);
    wait_done(ack ? 1'b0 : NACK_FLAGGED, 20);
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    int elapsed;
    b = 8'($urandom);
    accept(b);
    run_inhibit();
    run_frame(b, 4, 1'b1);
    wait_done(1'b1, TMO + 50);
    elapsed = done_cyc - last_fall;
    total_cnt++;
    if (elapsed < TMO + 1 || elapsed > TMO + 5)
      $display("FAIL timeout_len: got %0d want %0d..%0d",
               elapsed, TMO + 1, TMO + 5);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'($urandom);
    accept(b);
    run_inhibit();
    run_frame(b, 3, 1'b1);
    #2;
    resetLow = 1'b0;
    #1;
    total_cnt++;
    if (ps2ClkDriveLow !== 1'b0 || ps2DatDriveLow !== 1'b0
        || busy !== 1'b0 || cmdReady !== 1'b1 || txDone !== 1'b0)
      $display("FAIL reset_mid: c=%b d=%b busy=%b rdy=%b dn=%b want 0 0 0 1 0",
               ps2ClkDriveLow, ps2DatDriveLow, busy, cmdReady, txDone);
    else pass_cnt++;
    @(negedge clk);
    resetLow = 1'b1;
    test_send(8'hFF, 1'b1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmdData  = 8'h00;
    cmdValid = 1'b1;
    total_cnt++;
    if (cmdReady !== 1'b1)
      $display("FAIL b2b_ready: got %b want 1", cmdReady);
    else pass_cnt++;
    @(negedge clk);
    cmdData = 8'hF4;
    total_cnt++;
    if (busy !== 1'b1 || ps2ClkDriveLow !== 1'b1)
      $display("FAIL b2b_first: busy=%b clk=%b want 1 1",
               busy, ps2ClkDriveLow);
    else pass_cnt++;
    run_inhibit();
    run_frame(8'h00, 11, 1'b1);
    wait_done(1'b0, 20);
    @(negedge clk);
    cmdValid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || ps2ClkDriveLow !== 1'b1)
      $display("FAIL b2b_second: busy=%b clk=%b want 1 1",
               busy, ps2ClkDriveLow);
    else pass_cnt++;
    run_inhibit();
    run_frame(8'hF4, 11, 1'b1);
    wait_done(1'b0, 20);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      test_send(8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 1'b1);
    test_send(8'h01, 1'b1);
    test_send(8'($urandom), 1'b0);
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, %0d/%0d so far",
             pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same open-drain PS2_CLK/PS2_DAT lines the keyboard receiver listens on. It takes a byte over a valid/ready handshake, inhibits the bus, issues the request-to-send, shifts out data, parity and stop on device clock edges, and checks the device acknowledge. It sits beside the keyboard tracker in the top level. Pad tristating (`line = driveLow ? 0 : 1'bz`) is done at the top level.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-low inhibit length in clk cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum clk cycles between device falling edges (15 ms), and for final bus release.

- `clk`, input, 1: system clock (CLOCK_50).
- `resetLow`, input, 1: reset, asynchronous and active-low.
- `cmdData`, input, 8: byte to send; sampled on accept.
- `cmdValid`, input, 1: request to send `cmdData`.
- `cmdReady`, output, 1: high only in IDLE; a byte is accepted when `cmdValid & cmdReady` at a rising edge.
- `ps2ClkIn`, input, 1: raw PS2_CLK pad level.
- `ps2DatIn`, input, 1: raw PS2_DAT pad level.
- `ps2ClkDriveLow`, output, 1: 1 pulls PS2_CLK low; 0 releases it.
- `ps2DatDriveLow`, output, 1: 1 pulls PS2_DAT low; 0 releases it.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `txDone`, output, 1: one-cycle pulse when a transaction ends (success or failure).
- `txError`, output, 1: one-cycle pulse coincident with `txDone` when the transaction failed.

## Operation
- `ps2ClkIn` and `ps2DatIn` each pass through a 2-flop synchronizer. `fallEdge` = previous synced clk 1 and current synced clk 0. It is a one-cycle pulse.
- Accepting a byte loads the 10-bit shift register {stop=1, parity=~^cmdData (odd), cmdData}. It also clears the bit counter and the cycle counter.
- **IDLE**
  - Both lines released, `cmdReady`=1.
  - On accept, go to INHIBIT.
- **INHIBIT**
  - `ps2ClkDriveLow`=1, `ps2DatDriveLow`=0, for exactly INHIBIT_CYCLES cycles.
  - Then go to START.
- **START** (1 cycle)
  - Clock and data both driven low.
  - Then go to SEND.
- **SEND**
  - Clock released; data held low (start bit) until the first `fallEdge`.
  - On each `fallEdge`: `ps2DatDriveLow` ← ~shift[0], shift right, bit counter +1.
  - After the 10th `fallEdge` (stop bit = release), go to ACK.
- **ACK**
  - On the next `fallEdge`, sample synced data: 0 is ACK, 1 is NACK.
  - Then go to RELEASE.
- **RELEASE**
  - Wait until synced clock and data are both 1.
  - Then pulse `txDone` (plus `txError` on NACK) and return to IDLE.
- **Timeout**
  - The cycle counter runs in SEND, ACK and RELEASE, and clears on every `fallEdge`.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses `txDone` and `txError`, and returns to IDLE.
- `cmdValid` is ignored while busy. `cmdData` changes after accept have no effect.
- **Reset** (any time, including mid-frame)
  - State IDLE, both drive outputs 0 (bus released), `busy`=0, `txDone`=0, `txError`=0, counters 0, synchronizers 1.
  - `cmdReady`=1 while in reset (combinational from IDLE).

## Timing
- Accept at edge T: INHIBIT starts at T+1, `ps2ClkDriveLow`=1 from T+1.
- START occupies cycle T+1+INHIBIT_CYCLES. SEND starts the following cycle.
- Device falling edge to data change on `ps2DatDriveLow`: 3 clk cycles (2 sync, 1 register).
- `txDone` is high in the cycle the state is still RELEASE or timing out. `cmdReady` is 1 in the next cycle, so back-to-back commands are possible.
- All outputs are registered except `cmdReady` and `busy` (state decode).

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined:
  - ACK state samples data on the 11th falling edge.
  - NACK (data high) sets `txError` on completion.
- `PS2_TX_ACK_CHECK_EN` undefined:
  - The 11th falling edge is still awaited, but data is not evaluated.
  - `txError` is asserted only on timeout.

## Test plan
Bench parameters: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model toggling clock at 40-cycle period.
- Send 0xED, device ACKs:
  - `ps2DatDriveLow` after falling edges 1–10 is 0,1,0,0,1,0,0,0,0,0 (parity 1, stop released).
  - Then `txDone`=1, `txError`=0, `cmdReady`=1 the next cycle.
- Send 0x01:
  - Parity bit driven as data-low (`ps2DatDriveLow`=1 after edge 9).
  - Clock held low exactly 8 cycles, then START for 1 cycle.
- Device NACKs (data high on 11th edge) with macro defined:
  - `txDone`=`txError`=1 in the same cycle.
  - With macro undefined: `txError`=0.
- Device stops clocking after bit 4:
  - 200 cycles after the last falling edge, both drives 0 and `txDone`=`txError`=1.
  - IDLE next cycle.
- `resetLow` pulsed low mid-SEND:
  - Drives 0, `busy`=0 immediately (asynchronous).
  - After release, a new 0xFF accepted and sent correctly.
- `cmdValid` held high with 0x00 then 0xF4:
  - Second byte accepted only on the cycle after the first `txDone`.
  - 0x00 sends parity as released (1).
